pclk_step_sequencer: RTL and testbench

//  Generates the four-phase trapezoidal power clocks (clkpos/clkneg pairs) that drive the adiabatic

---
 rtl/adiabatic_pkg.sv | 27 ++
 rtl/pclk_phase_map.sv | 36 +++
 rtl/pclk_step_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pclk_step_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adiabatic_pkg.sv
// Shared types for the four-phase adiabatic power-clock sequencer.
// The segment type names where a phase sits within its own trapezoid.
package adiabatic_pkg;

  localparam int NPHASE = 4;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    PRECHG = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    TDIS   = 3'd4
  } pclk_state_t;

  typedef enum logic [1:0] {
    SEG_UP   = 2'd0,
    SEG_HOLD = 2'd1,
    SEG_DN   = 2'd2,
    SEG_WAIT = 2'd3
  } pclk_seg_t;

  // Phase k lags the global segment by k quarter periods.
  function automatic pclk_seg_t rel_seg(input logic [1:0] seg, input logic [1:0] k);
    return pclk_seg_t'(seg - k);
  endfunction

endpackage

// File: rtl/pclk_phase_map.sv
// Maps the global (segment, step) position onto one phase's clkpos level.
// Purely combinational; an inactive phase always sits at level 0.
module pclk_phase_map
  import adiabatic_pkg::*;
#(
  parameter int  NSTEP = 4,
  localparam int LW    = $clog2(NSTEP + 1),
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1
) (
  input  logic [1:0]    seg_i,
  input  logic [SW-1:0] step_i,
  input  logic [1:0]    k_i,
  input  logic          active_i,
  output logic [LW-1:0] lvl_o
);

  pclk_seg_t rel_s;

  // Trapezoid shape: ramp up, hold at full, ramp down, wait at zero.
  always_comb begin
    rel_s = rel_seg(seg_i, k_i);
    lvl_o = '0;
    if (active_i) begin
      unique case (rel_s)
        SEG_UP:   lvl_o = LW'(step_i) + LW'(1);
        SEG_HOLD: lvl_o = LW'(NSTEP);
        SEG_DN:   lvl_o = LW'(NSTEP - 1) - LW'(step_i);
        SEG_WAIT: lvl_o = '0;
        default:  lvl_o = '0;
      endcase
    end else begin
      lvl_o = '0;
    end
  end

endmodule

// File: rtl/pclk_step_sequencer.sv
// Four-phase trapezoidal power-clock sequencer with tank precharge/discharge
// handshake. All outputs are registered from the next-state values.
module pclk_step_sequencer
  import adiabatic_pkg::*;
#(
  parameter int  NSTEP      = 4,
  parameter int  PRECHG_CYC = 8,
  parameter int  CNTW       = 16,
  localparam int LW         = $clog2(NSTEP + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         stop_i,
  output logic [NPHASE-1:0][LW-1:0]    lvl_pos_o,
  output logic [NPHASE-1:0][LW-1:0]    lvl_neg_o,
  output logic [NPHASE-1:0][NSTEP:0]   tank_sel_o,
  output logic                         tank_chg_o,
  output logic                         tank_dis_o,
  output logic [NPHASE-1:0]            active_o,
  output logic                         busy_o,
  output logic [CNTW-1:0]              periods_o
);

  localparam int SW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int PW = (PRECHG_CYC > 1) ? $clog2(PRECHG_CYC) : 1;
  localparam int TW = NSTEP + 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(NSTEP - 1);
  localparam logic [PW-1:0] CNT_LAST  = PW'(PRECHG_CYC - 1);

  pclk_state_t               state_q, state_d;
  logic [PW-1:0]             cnt_q, cnt_d;
  logic [1:0]                seg_q, seg_d;
  logic [SW-1:0]             step_q, step_d;
  logic [NPHASE-1:0]         active_q, active_d;
  logic [CNTW-1:0]           periods_q, periods_d;
  logic                      run_next_s, drain_next_s;
  logic [NPHASE-1:0][LW-1:0] lvl_pos_d, lvl_pos_q, lvl_neg_d, lvl_neg_q;
  logic [NPHASE-1:0][TW-1:0] tank_sel_d, tank_sel_q;
  logic                      tank_chg_d, tank_chg_q, tank_dis_d, tank_dis_q;
  logic                      busy_d, busy_q;

  // Ramp position and period counter; they only advance while phases are live.
  always_comb begin
    run_next_s   = ((state_q == PRECHG) && !stop_i && (cnt_q == CNT_LAST)) ||
                   ((state_q == RUN) && !stop_i);
    drain_next_s = ((state_q == RUN) && stop_i) || (state_q == DRAIN);
    seg_d        = 2'd0;
    step_d       = '0;
    periods_d    = periods_q;
    if ((state_q == RUN) || (state_q == DRAIN)) begin
      if (step_q == STEP_LAST) begin
        step_d = '0;
        seg_d  = seg_q + 2'd1;
        if ((state_q == RUN) && (seg_q == 2'd3) && (periods_q != {CNTW{1'b1}})) begin
          periods_d = periods_q + CNTW'(1);
        end else begin
          periods_d = periods_q;
        end
      end else begin
        step_d = step_q + SW'(1);
        seg_d  = seg_q;
      end
    end else begin
      seg_d  = 2'd0;
      step_d = '0;
    end
  end

  // Phases join at the start of their ramp-up and leave once they reach wait while draining.
  always_comb begin
    active_d = '0;
    for (int k = 0; k < NPHASE; k++) begin
      if (run_next_s) begin
        active_d[k] = active_q[k] | ((seg_d == 2'(k)) && (step_d == '0));
      end else if (drain_next_s) begin
        active_d[k] = active_q[k] & (rel_seg(seg_d, 2'(k)) != SEG_WAIT);
      end else begin
        active_d[k] = 1'b0;
      end
    end
  end

  // FSM next state and the precharge/discharge cycle count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      OFF: begin
        if (start_i) begin
          state_d = PRECHG;
          cnt_d   = '0;
        end else begin
          state_d = OFF;
        end
      end
      PRECHG: begin
        if (stop_i) begin
          state_d = TDIS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (active_d == '0) begin
          state_d = TDIS;
          cnt_d   = '0;
        end else begin
          state_d = DRAIN;
        end
      end
      TDIS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  for (genvar k = 0; k < NPHASE; k++) begin : g_phase
    pclk_phase_map #(.NSTEP(NSTEP)) u_map (
      .seg_i    (seg_d),
      .step_i   (step_d),
      .k_i      (2'(k)),
      .active_i (active_d[k]),
      .lvl_o    (lvl_pos_d[k])
    );
  end

  // Complementary rail, one-hot tank select and handshake flags.
  always_comb begin
    for (int k = 0; k < NPHASE; k++) begin
      lvl_neg_d[k]  = LW'(NSTEP) - lvl_pos_d[k];
      tank_sel_d[k] = TW'(1) << lvl_pos_d[k];
    end
    tank_chg_d = (state_d == PRECHG);
    tank_dis_d = (state_d == TDIS);
    busy_d     = (state_d != OFF);
  end

  // State and output registers; reset aborts immediately without draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      seg_q      <= 2'd0;
      step_q     <= '0;
      active_q   <= '0;
      periods_q  <= '0;
      lvl_pos_q  <= '0;
      lvl_neg_q  <= {NPHASE{LW'(NSTEP)}};
      tank_sel_q <= {NPHASE{TW'(1)}};
      tank_chg_q <= 1'b0;
      tank_dis_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      step_q     <= step_d;
      active_q   <= active_d;
      periods_q  <= periods_d;
      lvl_pos_q  <= lvl_pos_d;
      lvl_neg_q  <= lvl_neg_d;
      tank_sel_q <= tank_sel_d;
      tank_chg_q <= tank_chg_d;
      tank_dis_q <= tank_dis_d;
      busy_q     <= busy_d;
    end
  end

  assign lvl_pos_o  = lvl_pos_q;
  assign lvl_neg_o  = lvl_neg_q;
  assign tank_sel_o = tank_sel_q;
  assign tank_chg_o = tank_chg_q;
  assign tank_dis_o = tank_dis_q;
  assign active_o   = active_q;
  assign busy_o     = busy_q;
  assign periods_o  = periods_q;

endmodule

// File: tb/tb_pclk_step_sequencer.sv
// Self-checking bench for pclk_step_sequencer: a time-based behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pclk_step_sequencer;

  localparam int NSTEP = 4;
  localparam int PRECHG_CYC = 8;
  localparam int CNTW = 4;
  localparam int LW = 3;
  localparam int NP = 4;
  localparam int M_OFF = 0, M_PRE = 1, M_RUN = 2, M_DRN = 3, M_TDIS = 4;

  logic clk = 1'b0;
  logic rst_n, start_i, stop_i;
  logic [NP-1:0][LW-1:0]  lvl_pos_o, lvl_neg_o;
  logic [NP-1:0][NSTEP:0] tank_sel_o;
  logic                   tank_chg_o, tank_dis_o, busy_o;
  logic [NP-1:0]          active_o;
  logic [CNTW-1:0]        periods_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pclk_step_sequencer #(.NSTEP(NSTEP), .PRECHG_CYC(PRECHG_CYC), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .lvl_pos_o  (lvl_pos_o),
    .lvl_neg_o  (lvl_neg_o),
    .tank_sel_o (tank_sel_o),
    .tank_chg_o (tank_chg_o),
    .tank_dis_o (tank_dis_o),
    .active_o   (active_o),
    .busy_o     (busy_o),
    .periods_o  (periods_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: m_t counts cycles since RUN entry.
  int        m_st = M_OFF, m_cnt = 0, m_t = 0, m_per = 0;
  bit [NP-1:0] m_act = '0;
  bit        m_valid = 1'b0, m_rst_edge = 1'b1;

  function automatic int m_rel(input int k);
    return ((m_t / NSTEP) - k + 4) % 4;
  endfunction

  function automatic int m_level(input int k);
    int stp;
    stp = m_t % NSTEP;
    if (!m_act[k]) return 0;
    case (m_rel(k))
      0: return stp + 1;
      1: return NSTEP;
      2: return NSTEP - 1 - stp;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int old;
    m_rst_edge = !rst_n;
    if (!rst_n) begin
      m_st = M_OFF; m_cnt = 0; m_t = 0; m_act = '0; m_per = 0; m_valid = 1'b1;
      return;
    end
    old = m_st;
    case (m_st)
      M_OFF: if (start_i) begin m_st = M_PRE; m_cnt = 0; end
      M_PRE: begin
        if (stop_i) begin m_st = M_TDIS; m_cnt = 0; end
        else if (m_cnt == PRECHG_CYC - 1) begin m_st = M_RUN; m_t = 0; end
        else m_cnt++;
      end
      M_RUN, M_DRN: begin
        if (m_st == M_RUN && ((m_t + 1) % (4 * NSTEP)) == 0 && m_per < (1 << CNTW) - 1) m_per++;
        if (m_st == M_RUN && stop_i) m_st = M_DRN;
        m_t++;
      end
      M_TDIS: begin
        if (m_cnt == PRECHG_CYC - 1) m_st = M_OFF;
        else m_cnt++;
      end
      default: m_st = M_OFF;
    endcase
    if (m_st == M_RUN) begin
      for (int k = 0; k < NP; k++) m_act[k] = (m_t >= k * NSTEP);
    end else if (m_st == M_DRN) begin
      for (int k = 0; k < NP; k++) if (m_rel(k) == 3) m_act[k] = 1'b0;
      if (old == M_DRN && m_act == '0) begin m_st = M_TDIS; m_cnt = 0; end
    end else begin
      m_act = '0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model plus rail invariants.
  int prev_lvl [NP];
  bit have_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      for (int k = 0; k < NP; k++) begin
        int e, d;
        e = m_level(k);
        chk($sformatf("lvl_pos[%0d]", k), lvl_pos_o[k], e);
        chk($sformatf("lvl_neg[%0d]", k), lvl_neg_o[k], NSTEP - e);
        chk($sformatf("tank_sel[%0d]", k), tank_sel_o[k], 64'd1 << e);
        chk("rail_sum", int'(lvl_pos_o[k]) + int'(lvl_neg_o[k]), NSTEP);
        chk("onehot", $countones(tank_sel_o[k]), 1);
        if (have_prev && !m_rst_edge) begin
          d = int'(lvl_pos_o[k]) - prev_lvl[k];
          if (d < 0) d = -d;
          chk("step_rule", d <= 1, 1);
        end
        prev_lvl[k] = int'(lvl_pos_o[k]);
      end
      have_prev = 1'b1;
      chk("active", active_o, m_act);
      chk("tank_chg", tank_chg_o, m_st == M_PRE);
      chk("tank_dis", tank_dis_o, m_st == M_TDIS);
      chk("busy", busy_o, m_st != M_OFF);
      chk("periods", periods_o, m_per);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic s, input logic p);
    start_i = s; stop_i = p;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0;
  endtask

  task automatic wait_t(input int tmod, input int per);
    int n = 0;
    while (!(m_st == M_RUN && (m_t % per) == tmod) && n < 300) begin
      @(negedge clk); n++;
    end
    chk("wait_run_timeout", n < 300, 1);
  endtask

  task automatic wait_off(output int dis_cyc, output int max_hi, output logic [NP-1:0] act_at_dis);
    int n = 0;
    bit seen = 1'b0;
    dis_cyc = 0; max_hi = 0; act_at_dis = '1;
    while (busy_o && n < 300) begin
      if (tank_dis_o) begin
        if (!seen) act_at_dis = active_o;
        seen = 1'b1;
        dis_cyc++;
      end
      for (int k = 1; k < NP; k++) if (int'(lvl_pos_o[k]) > max_hi) max_hi = int'(lvl_pos_o[k]);
      @(negedge clk); n++;
    end
    chk("off_timeout", n < 300, 1);
  endtask

  int seq [16] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0, 0, 0, 0};

  initial begin
    int dis, hi;
    logic [NP-1:0] act;
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", busy_o, 0);
    chk("rst_lvl_neg0", lvl_neg_o[0], 4);
    chk("rst_tank_sel0", tank_sel_o[0], 1);

    pulse(1'b0, 1'b1);
    chk("stop_in_off", busy_o, 0);

    // Startup: 8 precharge cycles then the trapezoid sequence
    pulse(1'b1, 1'b0);
    for (int i = 0; i < PRECHG_CYC; i++) begin
      chk($sformatf("startup_chg[%0d]", i), tank_chg_o, 1);
      @(negedge clk);
    end
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("seq_p0[%0d]", j), lvl_pos_o[0], seq[j % 16]);
      chk($sformatf("seq_p1[%0d]", j), lvl_pos_o[1], (j < 4) ? 0 : seq[(j - 4) % 16]);
      start_i = (j == 10);
      @(negedge clk);
    end
    start_i = 1'b0;

    // Stop mid-run at seg 1, step 2
    wait_t(6, 16);
    pulse(1'b0, 1'b1);
    wait_off(dis, hi, act);
    chk("mid_dis_cycles", dis, 8);
    chk("mid_act_at_dis", act, 0);

    // Stop during startup, start and stop together in OFF
    pulse(1'b1, 1'b1);
    wait_t(1, 1 << 20);
    pulse(1'b0, 1'b1);
    wait_off(dis, hi, act);
    chk("startup_hi_phases", hi, 0);
    chk("startup_dis_cycles", dis, 8);

    // Stop during precharge
    pulse(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    pulse(1'b0, 1'b1);
    wait_off(dis, hi, act);
    chk("prechg_dis_cycles", dis, 8);

    // Reset mid-run, then clean restart
    pulse(1'b1, 1'b0);
    wait_t(5, 16);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_lvl0", lvl_pos_o[0], 0);
    chk("midrst_neg0", lvl_neg_o[0], 4);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_active", active_o, 0);
    pulse(1'b1, 1'b0);
    repeat (PRECHG_CYC) @(negedge clk);
    chk("restart_lvl0", lvl_pos_o[0], 1);

    // Random start/stop traffic
    for (int i = 0; i < 600; i++) begin
      start_i = ($urandom_range(0, 19) == 0);
      stop_i  = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    start_i = 1'b0; stop_i = 1'b0;
    pulse(1'b0, 1'b1);
    wait_off(dis, hi, act);

    // Period counter and saturation
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse(1'b1, 1'b0);
    repeat (PRECHG_CYC + 48) @(negedge clk);
    chk("periods_3", periods_o, 3);
    repeat (20 * 16) @(negedge clk);
    chk("periods_sat", periods_o, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
